// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_scan_ctrl_pkg: matrix geometry, scan FSM states, scan-result classes and classifier
package keypad_scan_ctrl_pkg;
  localparam int ROW_N = 5;
  localparam int COL_N = 4;
  localparam int KEYS = ROW_N * COL_N;
  localparam int CODE_W = $clog2(KEYS);
  localparam int RW = $clog2(ROW_N);
  typedef enum logic [1:0] {SETTLE, SAMPLE, EVAL} scan_state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_class_e;
  typedef struct packed {
    scan_class_e cls;
    logic [CODE_W-1:0] code;
  } scan_result_t;
  function automatic scan_result_t classify(input logic [KEYS-1:0] img);
    scan_result_t r;
    int n;
    n = 0;
    r.code = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (img[i]) begin
        n++;
        r.code = CODE_W'(i);
      end
    end
    r.cls = n == 0 ? NONE : n == 1 ? SINGLE : MULTI;
    if (n != 1) r.code = '0;
    return r;
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: key-code handshake between the scanner and its consumer
interface keypad_scan_ctrl_if;
  logic readn;
  logic RDY;
  logic [keypad_scan_ctrl_pkg::CODE_W-1:0] key_code;
  logic overrun;
  modport master(input readn, output RDY, key_code, overrun);
  modport slave(output readn, input RDY, key_code, overrun);
endinterface

// File: rtl/keypad_scan_ctrl_debounce.sv
// keypad_scan_ctrl_debounce: whole-scan debounce producing one accept per press
module keypad_scan_ctrl_debounce
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 400
) (
  input  logic         clk_100mhz,
  input  logic         RSTN,
  input  logic         eval,
  input  scan_result_t res,
  output logic         accept
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  scan_result_t prev;
  logic [CW-1:0] cnt;
  logic reported, same, hit, rearm;
  assign same = res == prev;
  assign hit = eval && (same ? cnt == CW'(DEBOUNCE_SCANS - 1) : DEBOUNCE_SCANS == 1);
  assign accept = hit && res.cls == SINGLE && !reported;
  assign rearm = hit && res.cls == NONE;
  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      prev <= '{NONE, '0};
      cnt <= '0;
      reported <= 1'b0;
    end else if (eval) begin
      prev <= res;
      cnt <= !same ? CW'(1) : cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + CW'(1);
      reported <= accept || (reported && !rearm);
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 5x4 matrix row scanner with whole-scan debounce and RDY/readn key handshake
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 1000,
  parameter int DEBOUNCE_SCANS = 400
) (
  input  logic               clk_100mhz,
  input  logic               RSTN,
  input  logic [COL_N-1:0]   K_COL,
  output logic [ROW_N-1:0]   K_ROW,
  keypad_scan_ctrl_if.master kp
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  scan_state_e state, state_n;
  logic [RW-1:0] row, row_n;
  logic [SW-1:0] cnt, cnt_n;
  logic [COL_N-1:0] col_s1, col_s2;
  logic [KEYS-1:0] image;
  logic settled, last_row, eval, accept, rd;
  scan_result_t res;
  assign settled = cnt == SW'(SETTLE_CYC - 1);
  assign last_row = row == RW'(ROW_N - 1);
  assign eval = state == EVAL;
  assign K_ROW = ~(ROW_N'(1) << row);
  assign res = classify(image);
  assign rd = !kp.readn && kp.RDY;
  always_comb begin
    state_n = state == SETTLE ? (settled ? SAMPLE : SETTLE) : state == SAMPLE ? (last_row ? EVAL : SETTLE) : SETTLE;
    cnt_n = state == SETTLE && !settled ? cnt + SW'(1) : '0;
    row_n = eval ? '0 : state == SAMPLE && !last_row ? row + RW'(1) : row;
  end
  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      state <= SETTLE;
      row <= '0;
      cnt <= '0;
      col_s1 <= '1;
      col_s2 <= '1;
      image <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      cnt <= cnt_n;
      col_s1 <= K_COL;
      col_s2 <= col_s1;
      if (state == SAMPLE) image[int'(row) * COL_N +: COL_N] <= ~col_s2;
    end
  end
  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      kp.RDY <= 1'b0;
      kp.key_code <= '0;
      kp.overrun <= 1'b0;
    end else begin
      kp.RDY <= accept || (kp.RDY && kp.readn);
      kp.overrun <= !rd && (kp.overrun || (accept && kp.RDY));
      if (accept) kp.key_code <= res.code;
    end
  end
  keypad_scan_ctrl_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
    .clk_100mhz(clk_100mhz),
    .RSTN(RSTN),
    .eval(eval),
    .res(res),
    .accept(accept)
  );
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: scan-level reference model plus directed key sequences
module tb_keypad_scan_ctrl;
  localparam int SC = 4;
  localparam int DS = 3;
  localparam int PER = 5 * (SC + 1) + 1;
  localparam logic [4:0] STEP [6] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b01111};
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [19:0] keys = '0;
  logic [3:0] k_col;
  logic [4:0] k_row;
  int t = 0;
  int pass = 0;
  int total = 0;
  bit started = 0;
  bit m_rdy, m_ovr, armed;
  logic [4:0] m_code;
  int hist[$];
  keypad_scan_ctrl_if kp();
  keypad_scan_ctrl #(.SETTLE_CYC(SC), .DEBOUNCE_SCANS(DS)) dut (
    .clk_100mhz(clk),
    .RSTN(rstn),
    .K_COL(k_col),
    .K_ROW(k_row),
    .kp(kp)
  );
  always #5 clk = ~clk;
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      k_col[c] = 1'b1;
      for (int r = 0; r < 5; r++) if (keys[r * 4 + c] && !k_row[r]) k_col[c] = 1'b0;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0d", nm, act, exp, t);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic read_pulse();
    kp.readn = 1'b0;
    cyc(1);
    kp.readn = 1'b1;
  endtask
  task automatic to_scan();
    for (int i = 0; i < PER && t % PER != 0; i++) @(negedge clk);
  endtask
  always @(posedge clk) begin
    int r, run;
    bit acc, rd;
    started = 1;
    if (!rstn) begin
      t = 0;
      m_rdy = 0;
      m_ovr = 0;
      m_code = '0;
      armed = 1;
      hist.delete();
    end else begin
      acc = 0;
      r = 0;
      if (t % PER == PER - 1) begin
        r = $countones(keys) == 0 ? -1 : $countones(keys) > 1 ? -2 : $clog2(keys);
        hist.push_back(r);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != r) break;
          run++;
        end
        if (run == DS) begin
          if (r >= 0 && armed) begin
            acc = 1;
            armed = 0;
          end else if (r == -1) armed = 1;
        end
      end
      rd = !kp.readn && m_rdy;
      m_ovr = !rd && (m_ovr || (acc && m_rdy));
      m_rdy = acc || (m_rdy && !rd);
      if (acc) m_code = r[4:0];
      t++;
    end
  end
  always @(negedge clk) begin
    int p;
    logic [4:0] er;
    if (started) begin
      p = t % PER;
      er = ~(5'b1 << (p < PER - 1 ? p / (SC + 1) : 4));
      chk("k_row", k_row, er);
      chk("rdy", kp.RDY, m_rdy);
      chk("key_code", kp.key_code, m_code);
      chk("overrun", kp.overrun, m_ovr);
    end
  end
  initial begin
    kp.readn = 1'b1;
    cyc(3);
    rstn = 1'b1;
    chk("rst_krow", k_row, 5'b11110);
    chk("rst_rdy", kp.RDY, 0);
    chk("rst_code", kp.key_code, 0);
    chk("rst_ovr", kp.overrun, 0);
    for (int i = 0; i < 6; i++) begin
      chk("row_step", k_row, STEP[i]);
      if (i < 5) cyc(5);
    end
    cyc(1);
    chk("row_wrap", k_row, 5'b11110);
    keys = 20'b1 << 9;
    cyc(3 * PER - 1);
    chk("k9_pre", kp.RDY, 0);
    cyc(1);
    chk("k9_rdy", kp.RDY, 1);
    chk("k9_code", kp.key_code, 9);
    cyc(10 * PER);
    chk("k9_hold_rdy", kp.RDY, 1);
    chk("k9_hold_ovr", kp.overrun, 0);
    read_pulse();
    chk("read_clr", kp.RDY, 0);
    to_scan();
    keys = '0;
    cyc(3 * PER);
    keys = 20'b1 << 19;
    cyc(3 * PER);
    chk("k19_rdy", kp.RDY, 1);
    chk("k19_code", kp.key_code, 19);
    read_pulse();
    to_scan();
    for (int i = 0; i < 8; i++) begin
      keys = i % 2 == 0 ? 20'b1 : 20'b0;
      cyc(PER);
    end
    chk("bounce_rdy", kp.RDY, 0);
    keys = 20'b1 | (20'b1 << 6);
    cyc(5 * PER);
    chk("multi_rdy", kp.RDY, 0);
    keys = '0;
    cyc(3 * PER);
    keys = 20'b1 << 5;
    cyc(3 * PER);
    chk("k5_rdy", kp.RDY, 1);
    chk("k5_code", kp.key_code, 5);
    keys = '0;
    cyc(3 * PER);
    keys = 20'b1 << 7;
    cyc(3 * PER);
    chk("k7_rdy", kp.RDY, 1);
    chk("k7_code", kp.key_code, 7);
    chk("k7_ovr", kp.overrun, 1);
    read_pulse();
    chk("ovr_read_rdy", kp.RDY, 0);
    chk("ovr_read_ovr", kp.overrun, 0);
    read_pulse();
    chk("idle_read_code", kp.key_code, 7);
    to_scan();
    keys = '0;
    cyc(3 * PER);
    keys = 20'b1 << 2;
    cyc(3 * PER);
    chk("k2_rdy", kp.RDY, 1);
    keys = '0;
    cyc(3 * PER);
    keys = 20'b1 << 9;
    cyc(3 * PER - 1);
    read_pulse();
    chk("same_edge_rdy", kp.RDY, 1);
    chk("same_edge_code", kp.key_code, 9);
    chk("same_edge_ovr", kp.overrun, 0);
    to_scan();
    cyc(16);
    chk("mid_row3", k_row, 5'b10111);
    rstn = 1'b0;
    cyc(1);
    chk("mid_rst_krow", k_row, 5'b11110);
    chk("mid_rst_rdy", kp.RDY, 0);
    chk("mid_rst_code", kp.key_code, 0);
    chk("mid_rst_ovr", kp.overrun, 0);
    rstn = 1'b1;
    cyc(3 * PER - 1);
    chk("rerep_pre", kp.RDY, 0);
    cyc(1);
    chk("rerep_rdy", kp.RDY, 1);
    chk("rerep_code", kp.key_code, 9);
    cyc(5);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
